// File: rtl/alu_mdu_pkg.sv
// rtl/alu_mdu_pkg.sv - op codes, FSM states and op-class helpers for the execute unit
package alu_mdu_pkg;

    typedef enum logic [4:0] {
        OP_ADD    = 5'd0,
        OP_SUB    = 5'd1,
        OP_SLL    = 5'd2,
        OP_SLT    = 5'd3,
        OP_SLTU   = 5'd4,
        OP_XOR    = 5'd5,
        OP_SRL    = 5'd6,
        OP_SRA    = 5'd7,
        OP_OR     = 5'd8,
        OP_AND    = 5'd9,
        OP_BEQ    = 5'd10,
        OP_BNE    = 5'd11,
        OP_BLT    = 5'd12,
        OP_BGE    = 5'd13,
        OP_BLTU   = 5'd14,
        OP_BGEU   = 5'd15,
        OP_MUL    = 5'd16,
        OP_MULH   = 5'd17,
        OP_MULHSU = 5'd18,
        OP_MULHU  = 5'd19,
        OP_DIV    = 5'd20,
        OP_DIVU   = 5'd21,
        OP_REM    = 5'd22,
        OP_REMU   = 5'd23
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // MUL..REMU occupy 16..23, so bit 4 set and bit 3 clear
    function automatic logic is_muldiv(input logic [4:0] op);
        return op[4:3] == 2'b10;
    endfunction

    function automatic logic is_branch(input logic [4:0] op);
        return (op >= 5'd10) && (op <= 5'd15);
    endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// rtl/mdu_iter_core.sv - radix-2 shift-add multiplier / restoring divider on operand magnitudes
module mdu_iter_core
    import alu_mdu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic            kill_i,
    input  logic [4:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            done_o,
    output logic [XLEN-1:0] res_o
);

    localparam int CW = $clog2(XLEN);

    logic                busy_q, busy_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2*XLEN-1:0]   acc_q, acc_d, acc_nx;
    logic [XLEN-1:0]     dvs_q, dvs_d;
    logic                neg_q, neg_d;
    logic [4:0]          op_q, op_d;

    logic                sa, sb, a_neg, b_neg, start_neg;
    logic [XLEN-1:0]     a_mag, b_mag;
    logic [XLEN:0]       mul_sum, div_trial;
    logic [2*XLEN-1:0]   mul_next, div_next, prod;
    logic [XLEN-1:0]     quo, rem;

    assign sa        = (op_i == OP_MULH) || (op_i == OP_MULHSU) || (op_i == OP_DIV) || (op_i == OP_REM);
    assign sb        = (op_i == OP_MULH) || (op_i == OP_DIV) || (op_i == OP_REM);
    assign a_neg     = sa & a_i[XLEN-1];
    assign b_neg     = sb & b_i[XLEN-1];
    assign a_mag     = a_neg ? -a_i : a_i;
    assign b_mag     = b_neg ? -b_i : b_i;
    // remainder follows the dividend's sign; everything else follows the sign product
    assign start_neg = (op_i[2] && op_i[1]) ? a_neg : (a_neg ^ b_neg);

    // acc holds {partial product, multiplier} or {partial remainder, dividend/quotient}
    assign mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, dvs_q} : '0);
    assign mul_next  = {mul_sum, acc_q[XLEN-1:1]};
    assign div_trial = acc_q[2*XLEN-1:XLEN-1] - {1'b0, dvs_q};
    assign div_next  = div_trial[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                                       : {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    assign acc_nx    = op_q[2] ? div_next : mul_next;

    assign done_o = busy_q && (cnt_q == CW'(XLEN - 1));

    // result is taken from the final iteration's next value so it lands on the last edge
    assign prod = neg_q ? -acc_nx : acc_nx;
    assign quo  = neg_q ? -acc_nx[XLEN-1:0] : acc_nx[XLEN-1:0];
    assign rem  = neg_q ? -acc_nx[2*XLEN-1:XLEN] : acc_nx[2*XLEN-1:XLEN];

    always_comb begin
        res_o = rem;
        case (op_e'(op_q))
            OP_MUL:                         res_o = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:   res_o = prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:                res_o = quo;
            default:                        res_o = rem;
        endcase
    end

    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        acc_d  = acc_q;
        dvs_d  = dvs_q;
        neg_d  = neg_q;
        op_d   = op_q;
        if (kill_i) begin
            busy_d = 1'b0;
            cnt_d  = '0;
        end else if (start_i) begin
            busy_d = 1'b1;
            cnt_d  = '0;
            op_d   = op_i;
            neg_d  = start_neg;
            acc_d  = op_i[2] ? {{XLEN{1'b0}}, a_mag} : {{XLEN{1'b0}}, b_mag};
            dvs_d  = op_i[2] ? b_mag : a_mag;
        end else if (busy_q) begin
            acc_d = acc_nx;
            cnt_d = cnt_q + CW'(1);
            if (done_o) begin
                busy_d = 1'b0;
                cnt_d  = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            acc_q  <= '0;
            dvs_q  <= '0;
            neg_q  <= 1'b0;
            op_q   <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
            dvs_q  <= dvs_d;
            neg_q  <= neg_d;
            op_q   <= op_d;
        end
    end

endmodule

// File: rtl/alu_mdu_iter.sv
// rtl/alu_mdu_iter.sv - registered execute unit: single-cycle ALU/branch plus iterative MUL/DIV
module alu_mdu_iter
    import alu_mdu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    input  logic            kill,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            branch_taken
);

    localparam int SHW = $clog2(XLEN);

    state_e          state_q, state_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            branch_q, branch_d;

    logic [XLEN-1:0] alu_res, core_res;
    logic            alu_br, corner, core_start, core_done;
    logic [SHW-1:0]  shamt;
    logic            lt_s, lt_u, eq, b_zero, ovf;

    assign shamt  = operand_b[SHW-1:0];
    assign lt_s   = $signed(operand_a) < $signed(operand_b);
    assign lt_u   = operand_a < operand_b;
    assign eq     = operand_a == operand_b;
    assign b_zero = operand_b == '0;
    assign ovf    = (operand_a == {1'b1, {(XLEN-1){1'b0}}}) && (operand_b == '1);

    // corner flags the div/rem cases that finish here instead of in the iterative core
    always_comb begin
        alu_res = '0;
        alu_br  = 1'b0;
        corner  = 1'b0;
        case (op_e'(op))
            OP_ADD:  alu_res = operand_a + operand_b;
            OP_SUB:  alu_res = operand_a - operand_b;
            OP_SLL:  alu_res = operand_a << shamt;
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, lt_s};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, lt_u};
            OP_XOR:  alu_res = operand_a ^ operand_b;
            OP_SRL:  alu_res = operand_a >> shamt;
            OP_SRA:  alu_res = XLEN'($signed(operand_a) >>> shamt);
            OP_OR:   alu_res = operand_a | operand_b;
            OP_AND:  alu_res = operand_a & operand_b;
            OP_BEQ:  alu_br  = eq;
            OP_BNE:  alu_br  = !eq;
            OP_BLT:  alu_br  = lt_s;
            OP_BGE:  alu_br  = !lt_s;
            OP_BLTU: alu_br  = lt_u;
            OP_BGEU: alu_br  = !lt_u;
            OP_DIV: begin
                corner  = b_zero | ovf;
                alu_res = b_zero ? '1 : operand_a;
            end
            OP_DIVU: begin
                corner  = b_zero;
                alu_res = '1;
            end
            OP_REM: begin
                corner  = b_zero | ovf;
                alu_res = b_zero ? operand_a : '0;
            end
            OP_REMU: begin
                corner  = b_zero;
                alu_res = operand_a;
            end
            default: ;
        endcase
        if (is_branch(op)) alu_res = {{(XLEN-1){1'b0}}, alu_br};
    end

    mdu_iter_core #(.XLEN(XLEN)) u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (core_start),
        .kill_i  (kill),
        .op_i    (op),
        .a_i     (operand_a),
        .b_i     (operand_b),
        .done_o  (core_done),
        .res_o   (core_res)
    );

    always_comb begin
        state_d    = state_q;
        result_d   = result_q;
        branch_d   = branch_q;
        core_start = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (in_valid && !kill) begin
                    if (is_muldiv(op) && !corner) begin
                        core_start = 1'b1;
                        state_d    = S_BUSY;
                    end else begin
                        result_d = alu_res;
                        branch_d = alu_br;
                        state_d  = S_DONE;
                    end
                end
            end
            S_BUSY: begin
                if (kill) begin
                    state_d = S_IDLE;
                end else if (core_done) begin
                    result_d = core_res;
                    branch_d = 1'b0;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (kill || out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            branch_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            branch_q <= branch_d;
        end
    end

    assign in_ready     = state_q == S_IDLE;
    assign out_valid    = state_q == S_DONE;
    assign result       = result_q;
    assign branch_taken = branch_q;

endmodule

// File: tb/tb_alu_mdu_iter.sv
// tb/tb_alu_mdu_iter.sv - directed self-checking bench for alu_mdu_iter at XLEN=32
module tb_alu_mdu_iter;
    import alu_mdu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  op = 5'd0;
    logic [31:0] operand_a = 32'd0;
    logic [31:0] operand_b = 32'd0;
    logic        kill = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        branch_taken;

    int n_checks = 0;
    int n_errors = 0;

    alu_mdu_iter #(.XLEN(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .op           (op),
        .operand_a    (operand_a),
        .operand_b    (operand_b),
        .kill         (kill),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .result       (result),
        .branch_taken (branch_taken)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // present one request for one cycle, then scramble the inputs to prove they were latched
    task automatic accept(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        op        = o;
        operand_a = a;
        operand_b = b;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        op        = OP_AND;
        operand_a = 32'hA5A5_5A5A;
        operand_b = 32'h0000_0003;
    endtask

    task automatic retire(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_ready_after"}, {31'd0, in_ready}, 32'd1);
    endtask

    task automatic exec(input string tag, input logic [4:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res,
                        input logic exp_br, input int exp_lat);
        int lat;
        accept(o, a, b);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_res"}, result, exp_res);
        check({tag, "_br"}, {31'd0, branch_taken}, {31'd0, exp_br});
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        retire(tag);
    endtask

    initial begin
        int seen;

        #2 rst_n = 1'b0;
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_branch", {31'd0, branch_taken}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        exec("add_wrap", OP_ADD, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 1);
        exec("sub", OP_SUB, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0, 1);
        exec("sra", OP_SRA, 32'h8000_0000, 32'h24, 32'hF800_0000, 1'b0, 1);
        exec("srl", OP_SRL, 32'h8000_0000, 32'h24, 32'h0800_0000, 1'b0, 1);
        exec("sll", OP_SLL, 32'h1, 32'd31, 32'h8000_0000, 1'b0, 1);
        exec("slt", OP_SLT, 32'hFFFF_FFFF, 32'h1, 32'h1, 1'b0, 1);
        exec("sltu", OP_SLTU, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 1);
        exec("bltu", OP_BLTU, 32'h1, 32'hFFFF_FFFF, 32'h1, 1'b1, 1);
        exec("blt", OP_BLT, 32'h1, 32'hFFFF_FFFF, 32'h0, 1'b0, 1);
        exec("bge", OP_BGE, 32'h1, 32'hFFFF_FFFF, 32'h1, 1'b1, 1);
        exec("undef", 5'd25, 32'h1234, 32'h5678, 32'h0, 1'b0, 1);

        exec("mul", OP_MUL, 32'd7, 32'd6, 32'd42, 1'b0, 33);
        exec("mulh", OP_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, 33);
        exec("mulhsu", OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 33);
        exec("mulhu", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 33);
        exec("div", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 33);
        exec("rem", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 33);
        exec("divu", OP_DIVU, 32'd100, 32'd7, 32'd14, 1'b0, 33);
        exec("remu", OP_REMU, 32'd100, 32'd7, 32'd2, 1'b0, 33);
        exec("divu_by0", OP_DIVU, 32'd100, 32'd0, 32'hFFFF_FFFF, 1'b0, 1);
        exec("remu_by0", OP_REMU, 32'd100, 32'd0, 32'd100, 1'b0, 1);
        exec("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1);
        exec("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1'b0, 1);

        // backpressure: result must hold while the consumer stalls
        accept(OP_XOR, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
        check("bp_first_valid", {31'd0, out_valid}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_hold_result", result, 32'hFF00_FF00);
            check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
            check("bp_hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        retire("bp");

        // kill at iteration 10 of a DIVU
        accept(OP_DIVU, 32'd1000, 32'd7);
        repeat (10) @(posedge clk);
        @(negedge clk);
        kill = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        check("kill_busy_valid", {31'd0, out_valid}, 32'd0);
        check("kill_busy_in_ready", {31'd0, in_ready}, 32'd1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        check("kill_no_late_valid", 32'(seen), 32'd0);
        exec("add_after_kill", OP_ADD, 32'd2, 32'd3, 32'd5, 1'b0, 1);

        // kill in IDLE drops the concurrent request
        @(negedge clk);
        op        = OP_ADD;
        operand_a = 32'd9;
        operand_b = 32'd9;
        in_valid  = 1'b1;
        kill      = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        kill     = 1'b0;
        check("kill_idle_valid", {31'd0, out_valid}, 32'd0);
        check("kill_idle_in_ready", {31'd0, in_ready}, 32'd1);

        // kill in DONE discards the presented result
        accept(OP_OR, 32'h1, 32'h2);
        @(negedge clk);
        kill = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        check("kill_done_valid", {31'd0, out_valid}, 32'd0);

        // async reset in the middle of a MUL
        exec("pre_rst_add", OP_ADD, 32'h10, 32'h20, 32'h30, 1'b0, 1);
        accept(OP_MUL, 32'd123, 32'd456);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_result", result, 32'd0);
        check("midrst_branch", {31'd0, branch_taken}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exec("mul_after_rst", OP_MUL, 32'd123, 32'd456, 32'd56088, 1'b0, 33);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
